// File: rtl/wb_mem_arbiter_pkg.sv
// Shared definitions for the Wishbone memory arbiter: FSM state encoding,
// port index constants and the streak counter width helper.
package wb_mem_arbiter_pkg;

   // Arbiter FSM states; the grant encodings line up with the one-hot grant_o layout.
   typedef enum logic [1:0] {
      ARB_IDLE    = 2'b00,
      ARB_GRANT_I = 2'b01,
      ARB_GRANT_D = 2'b10
   } arb_state_e;

   // Bit positions of each requester inside grant_o.
   localparam logic [0:0] PORT_I = 1'b0;
   localparam logic [0:0] PORT_D = 1'b1;

   // Instruction fetches always read whole words.
   localparam logic [3:0] SEL_ALL = 4'hF;

   // Counter width able to hold 0..max_streak; never narrower than one bit.
   function automatic int unsigned streak_width(input int unsigned max_streak);
      return (max_streak > 32'd0) ? $clog2(max_streak + 32'd1) : 32'd1;
   endfunction

endpackage

// File: rtl/wb_mem_arbiter_streak_ctr.sv
// Saturating up-counter with synchronous clear; tracks how many data grants
// have been handed out while the instruction port was kept waiting.
module wb_mem_arbiter_streak_ctr
   import wb_mem_arbiter_pkg::*;
#(
   parameter int unsigned W   = 3,
   parameter int unsigned MAX = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   localparam logic [W-1:0] MAX_C = W'(MAX);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: clear wins over increment, increment stops at MAX.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != MAX_C)) begin
         count_d = count_q + W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter in front of a single-port memory. The
// instruction and data ports share the memory; data normally wins a tie,
// but after MAX_D_STREAK back-to-back data wins against a waiting
// instruction request the instruction port is served. Every transfer is
// followed by one IDLE turnaround cycle in which arbitration happens.
module wb_mem_arbiter
   import wb_mem_arbiter_pkg::*;
#(
   parameter int unsigned AW           = 32,
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   // instruction port (read-only)
   input  logic [AW-1:0] iwb_adr_i,
   input  logic          iwb_cyc_i,
   input  logic          iwb_stb_i,
   output logic [31:0]   iwb_dat_o,
   output logic          iwb_ack_o,
   // data port
   input  logic [AW-1:0] dwb_adr_i,
   input  logic [31:0]   dwb_dat_i,
   input  logic          dwb_we_i,
   input  logic [3:0]    dwb_sel_i,
   input  logic          dwb_cyc_i,
   input  logic          dwb_stb_i,
   output logic [31:0]   dwb_dat_o,
   output logic          dwb_ack_o,
   output logic          dwb_err_o,
   // shared memory
   output logic [AW-1:0] mem_adr_o,
   output logic [31:0]   mem_dat_o,
   output logic          mem_we_o,
   output logic [3:0]    mem_sel_o,
   output logic          mem_cyc_o,
   output logic          mem_stb_o,
   input  logic [31:0]   mem_dat_i,
   input  logic          mem_ack_i,
   input  logic          mem_err_i,
   // current owner {data, instr}
   output logic [1:0]    grant_o
);

   localparam int unsigned     SW         = streak_width(MAX_D_STREAK);
   localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_D_STREAK);

   arb_state_e    state_q;
   arb_state_e    state_d;
   logic          rdy_q;
   logic          i_req_s;
   logic          d_req_s;
   logic          streak_inc_s;
   logic          streak_clr_s;
   logic [SW-1:0] d_streak;

   assign i_req_s = iwb_cyc_i & iwb_stb_i;
   assign d_req_s = dwb_cyc_i & dwb_stb_i;

   // Read data goes to both ports; only the owner's ack qualifies it.
   assign iwb_dat_o = mem_dat_i;
   assign dwb_dat_o = mem_dat_i;

   // Holds off arbitration for the first edge after reset release so the
   // earliest grant lands on the second edge with rst_n high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Arbitration and transfer completion; also decides streak count updates.
   always_comb begin
      state_d      = state_q;
      streak_inc_s = 1'b0;
      streak_clr_s = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (!i_req_s) begin
               streak_clr_s = 1'b1;
            end else begin
               streak_clr_s = 1'b0;
            end
            if (!rdy_q) begin
               state_d = ARB_IDLE;
            end else if (i_req_s && d_req_s) begin
               if (d_streak == STREAK_MAX) begin
                  state_d      = ARB_GRANT_I;
                  streak_clr_s = 1'b1;
               end else begin
                  state_d      = ARB_GRANT_D;
                  streak_inc_s = 1'b1;
               end
            end else if (i_req_s) begin
               state_d      = ARB_GRANT_I;
               streak_clr_s = 1'b1;
            end else if (d_req_s) begin
               state_d = ARB_GRANT_D;
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_GRANT_I: begin
            // A memory error on a fetch is ignored; only ack or abort ends it.
            if (!iwb_cyc_i || mem_ack_i) begin
               state_d = ARB_IDLE;
            end else begin
               state_d = ARB_GRANT_I;
            end
         end
         ARB_GRANT_D: begin
            if (!dwb_cyc_i || mem_ack_i || mem_err_i) begin
               state_d = ARB_IDLE;
            end else begin
               state_d = ARB_GRANT_D;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // Bus mux: memory follows the owner, acks/err return only to the owner.
   always_comb begin
      mem_adr_o = '0;
      mem_dat_o = 32'h0000_0000;
      mem_we_o  = 1'b0;
      mem_sel_o = 4'h0;
      mem_cyc_o = 1'b0;
      mem_stb_o = 1'b0;
      iwb_ack_o = 1'b0;
      dwb_ack_o = 1'b0;
      dwb_err_o = 1'b0;
      grant_o   = 2'b00;
      case (state_q)
         ARB_GRANT_I: begin
            mem_adr_o       = iwb_adr_i;
            mem_sel_o       = SEL_ALL;
            mem_cyc_o       = iwb_cyc_i;
            mem_stb_o       = iwb_stb_i;
            iwb_ack_o       = iwb_cyc_i & mem_ack_i;
            grant_o[PORT_I] = 1'b1;
         end
         ARB_GRANT_D: begin
            mem_adr_o       = dwb_adr_i;
            mem_dat_o       = dwb_dat_i;
            mem_we_o        = dwb_we_i;
            mem_sel_o       = dwb_sel_i;
            mem_cyc_o       = dwb_cyc_i;
            mem_stb_o       = dwb_stb_i;
            dwb_ack_o       = dwb_cyc_i & mem_ack_i;
            dwb_err_o       = dwb_cyc_i & mem_err_i;
            grant_o[PORT_D] = 1'b1;
         end
         default: begin
            grant_o = 2'b00;
         end
      endcase
   end

   wb_mem_arbiter_streak_ctr #(
      .W   (SW),
      .MAX (MAX_D_STREAK)
   ) u_streak (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (streak_clr_s),
      .inc_i   (streak_inc_s),
      .count_o (d_streak)
   );

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter: reset behaviour, single-port reads,
// tie-breaking with streak limit, stores, errors, aborts and mid-transfer reset.
module tb_wb_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic [31:0] iwb_adr_i;
   logic        iwb_cyc_i, iwb_stb_i;
   logic [31:0] iwb_dat_o;
   logic        iwb_ack_o;
   logic [31:0] dwb_adr_i, dwb_dat_i;
   logic        dwb_we_i;
   logic [3:0]  dwb_sel_i;
   logic        dwb_cyc_i, dwb_stb_i;
   logic [31:0] dwb_dat_o;
   logic        dwb_ack_o, dwb_err_o;
   logic [31:0] mem_adr_o, mem_dat_o;
   logic        mem_we_o;
   logic [3:0]  mem_sel_o;
   logic        mem_cyc_o, mem_stb_o;
   logic [31:0] mem_dat_i;
   logic        mem_ack_i, mem_err_i;
   logic [1:0]  grant_o;

   int checks   = 0;
   int failures = 0;

   wb_mem_arbiter #(.AW(32), .MAX_D_STREAK(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .iwb_adr_i(iwb_adr_i), .iwb_cyc_i(iwb_cyc_i), .iwb_stb_i(iwb_stb_i),
      .iwb_dat_o(iwb_dat_o), .iwb_ack_o(iwb_ack_o),
      .dwb_adr_i(dwb_adr_i), .dwb_dat_i(dwb_dat_i), .dwb_we_i(dwb_we_i),
      .dwb_sel_i(dwb_sel_i), .dwb_cyc_i(dwb_cyc_i), .dwb_stb_i(dwb_stb_i),
      .dwb_dat_o(dwb_dat_o), .dwb_ack_o(dwb_ack_o), .dwb_err_o(dwb_err_o),
      .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o), .mem_we_o(mem_we_o),
      .mem_sel_o(mem_sel_o), .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o),
      .mem_dat_i(mem_dat_i), .mem_ack_i(mem_ack_i), .mem_err_i(mem_err_i),
      .grant_o(grant_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge, away from it.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   logic [1:0] exp_g [6];

   initial begin
      exp_g = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
      rst_n = 1'b0;
      iwb_adr_i = 32'h0; iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
      dwb_adr_i = 32'h0; dwb_dat_i = 32'h0; dwb_we_i = 1'b0; dwb_sel_i = 4'h0;
      dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0;
      mem_dat_i = 32'h0; mem_ack_i = 1'b0; mem_err_i = 1'b0;

      // ---- reset state
      tick(); tick();
      chk("rst_grant", grant_o, 2'b00);
      chk("rst_cyc", mem_cyc_o, 1'b0);
      chk("rst_stb", mem_stb_o, 1'b0);

      // ---- I-only read at 0x100, requested as reset releases
      rst_n = 1'b1;
      iwb_adr_i = 32'h0000_0100; iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
      tick(); #1;
      chk("no_grant_first_edge", grant_o, 2'b00);
      tick(); #1;
      chk("i_grant", grant_o, 2'b01);
      chk("i_stb", mem_stb_o, 1'b1);
      chk("i_adr", mem_adr_o, 32'h0000_0100);
      chk("i_ack_early", iwb_ack_o, 1'b0);
      tick();
      mem_ack_i = 1'b1; mem_dat_i = 32'hCAFE_0100;
      #1;
      chk("i_ack", iwb_ack_o, 1'b1);
      chk("i_dat", iwb_dat_o, 32'hCAFE_0100);
      chk("i_ack_nonowner", dwb_ack_o, 1'b0);
      tick();
      mem_ack_i = 1'b0; iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
      #1;
      chk("i_turnaround", grant_o, 2'b00);
      chk("i_turnaround_cyc", mem_cyc_o, 1'b0);

      // ---- both requesting continuously: D,D,D,D,I,D
      iwb_adr_i = 32'h0000_0200; iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
      dwb_adr_i = 32'h0000_0300; dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
      dwb_we_i = 1'b0; dwb_sel_i = 4'hF;
      for (int k = 0; k < 6; k++) begin
         tick(); #1;
         chk($sformatf("streak_grant%0d", k), grant_o, exp_g[k]);
         mem_ack_i = 1'b1; mem_dat_i = 32'h1000_0000 + k;
         #1;
         if (exp_g[k] == 2'b10) begin
            chk($sformatf("streak_dack%0d", k), dwb_ack_o, 1'b1);
            chk($sformatf("streak_iack%0d", k), iwb_ack_o, 1'b0);
         end else begin
            chk($sformatf("streak_iack%0d", k), iwb_ack_o, 1'b1);
            chk($sformatf("streak_dack%0d", k), dwb_ack_o, 1'b0);
            chk("streak_idat", iwb_dat_o, 32'h1000_0004);
         end
         tick();
         mem_ack_i = 1'b0;
         #1;
         chk($sformatf("streak_idle%0d", k), grant_o, 2'b00);
      end

      // ---- D store, then I fetch while D inputs still show a write
      iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
      dwb_adr_i = 32'h0000_1000; dwb_dat_i = 32'hDEAD_BEEF;
      dwb_we_i = 1'b1; dwb_sel_i = 4'b0011;
      tick(); #1;
      chk("st_grant", grant_o, 2'b10);
      chk("st_we", mem_we_o, 1'b1);
      chk("st_sel", mem_sel_o, 4'b0011);
      chk("st_dat", mem_dat_o, 32'hDEAD_BEEF);
      chk("st_adr", mem_adr_o, 32'h0000_1000);
      mem_ack_i = 1'b1;
      tick();
      mem_ack_i = 1'b0; dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0;
      iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
      tick(); #1;
      chk("if_grant", grant_o, 2'b01);
      chk("if_we", mem_we_o, 1'b0);
      chk("if_sel", mem_sel_o, 4'hF);
      // memory error during an instruction grant is ignored
      mem_err_i = 1'b1;
      #1;
      chk("if_err_noack", iwb_ack_o, 1'b0);
      chk("if_err_nodErr", dwb_err_o, 1'b0);
      tick();
      mem_err_i = 1'b0;
      #1;
      chk("if_err_stay", grant_o, 2'b01);
      mem_ack_i = 1'b1;
      tick();
      mem_ack_i = 1'b0; iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;

      // ---- D error, then D abort
      dwb_we_i = 1'b0; dwb_sel_i = 4'hF; dwb_adr_i = 32'h0000_2000;
      dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
      tick(); #1;
      chk("err_grant", grant_o, 2'b10);
      mem_err_i = 1'b1;
      #1;
      chk("err_err", dwb_err_o, 1'b1);
      chk("err_noack", dwb_ack_o, 1'b0);
      tick();
      mem_err_i = 1'b0;
      #1;
      chk("err_idle", grant_o, 2'b00);
      chk("err_clear", dwb_err_o, 1'b0);
      tick(); #1;
      chk("abort_grant", grant_o, 2'b10);
      dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0; mem_ack_i = 1'b0;
      #1;
      chk("abort_cyc", mem_cyc_o, 1'b0);
      chk("abort_noack", dwb_ack_o, 1'b0);
      tick(); #1;
      chk("abort_idle", grant_o, 2'b00);

      // ---- reset during a stalled D grant
      iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
      dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
      tick(); #1;
      chk("rstmid_grant", grant_o, 2'b10);
      chk("rstmid_streak_pre", dut.d_streak, 3'd1);
      tick();
      rst_n = 1'b0; mem_ack_i = 1'b1; mem_err_i = 1'b1;
      #1;
      chk("rstmid_grant0", grant_o, 2'b00);
      chk("rstmid_cyc", mem_cyc_o, 1'b0);
      chk("rstmid_stb", mem_stb_o, 1'b0);
      chk("rstmid_dack", dwb_ack_o, 1'b0);
      chk("rstmid_iack", iwb_ack_o, 1'b0);
      chk("rstmid_derr", dwb_err_o, 1'b0);
      chk("rstmid_streak", dut.d_streak, 3'd0);
      tick(); #1;
      chk("rstmid_hold", grant_o, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_mem_arbiter.md
WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, meaning Wishbone address width.
REQ-002 SHALL have parameter MAX_D_STREAK, default 4, meaning consecutive data grants allowed while the instruction port waits.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports iwb_adr_i AW, iwb_cyc_i 1, iwb_stb_i 1 (inputs) and iwb_dat_o 32, iwb_ack_o 1 (outputs): instruction port, read-only.
REQ-006 SHALL have ports dwb_adr_i AW, dwb_dat_i 32, dwb_we_i 1, dwb_sel_i 4, dwb_cyc_i 1, dwb_stb_i 1 (inputs) and dwb_dat_o 32, dwb_ack_o 1, dwb_err_o 1 (outputs): data port.
REQ-007 SHALL have ports mem_adr_o AW, mem_dat_o 32, mem_we_o 1, mem_sel_o 4, mem_cyc_o 1, mem_stb_o 1 (outputs) and mem_dat_i 32, mem_ack_i 1, mem_err_i 1 (inputs): shared single-port memory.
REQ-008 SHALL have port grant_o  output  2  one-hot current owner {data, instr}; 2'b00 when idle.

Function
REQ-009 SHALL implement states IDLE, GRANT_I, GRANT_D in a registered FSM.
REQ-010 IDLE: request = cyc&stb; if only one port requests, grant it next cycle; if both request, grant D unless d_streak == MAX_D_STREAK, then grant I.
REQ-011 Grant decision is registered: request seen in IDLE at cycle N -> mem_cyc_o/mem_stb_o high from N+1.
REQ-012 In GRANT_x, mem_* outputs SHALL mirror the granted port combinationally; in IDLE mem_cyc_o, mem_stb_o, mem_we_o = 0, mem_adr_o/mem_dat_o = 0, mem_sel_o = 0.
REQ-013 In GRANT_I, mem_we_o = 0 and mem_sel_o = 4'hF regardless of data-port inputs.
REQ-014 mem_ack_i SHALL route combinationally to the owner's ack only, same cycle; the non-owner's ack stays 0.
REQ-015 iwb_dat_o and dwb_dat_o SHALL both carry mem_dat_i; only the owner's ack qualifies it.
REQ-016 mem_err_i in GRANT_D SHALL drive dwb_err_o for that cycle and end the transfer like an ack; mem_err_i in GRANT_I SHALL be ignored (no ack) and the FSM stays in GRANT_I until ack.
REQ-017 On owner ack/err, FSM SHALL return to IDLE next cycle (one mandatory turnaround cycle; no back-to-back grant).
REQ-018 If the owner drops cyc before ack (abort), FSM SHALL return to IDLE next cycle, mem_cyc_o following owner cyc combinationally (low that cycle).
REQ-019 d_streak (width clog2(MAX_D_STREAK+1)) SHALL increment, saturating at MAX_D_STREAK, on each D grant made while I requests; it clears on any I grant or whenever I is not requesting in IDLE.
REQ-020 A request arriving while the other port owns the bus SHALL wait, with no ack, until IDLE arbitration.
REQ-021 grant_o SHALL equal {state==GRANT_D, state==GRANT_I}.

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, d_streak 0, grant_o 0, all mem_* strobes and all acks/err 0, including mid-transfer.
REQ-023 First grant after reset release SHALL occur no earlier than the second rising edge with rst_n high.

Structure
REQ-024 State encoding (ARB_IDLE, ARB_GRANT_I, ARB_GRANT_D) and port-index constants SHALL live in the shared core defines header alongside existing defines.
REQ-025 A sub-module arb_streak_ctr (saturating counter with clear) is natural; everything else is flat.

Verification
REQ-026 I-only read, adr 0x100, memory acks 1 cycle after stb -> mem_stb_o at N+1, iwb_ack_o at N+2 with mem word, grant_o 01.
REQ-027 I and D requesting same cycle in IDLE, MAX_D_STREAK=4 -> D granted first; I granted after D ack plus one IDLE cycle.
REQ-028 D requests continuously for 6 transfers with I waiting -> grants D,D,D,D,I, then D; I never waits more than 4 D grants.
REQ-029 D store 0xDEADBEEF sel 4'b0011 to 0x1000 -> mem_we_o 1, mem_sel_o 0011, mem_dat_o 0xDEADBEEF; I-grant never shows mem_we_o 1.
REQ-030 mem_err_i during GRANT_D -> dwb_err_o 1 for one cycle, dwb_ack_o 0, IDLE next; D drops cyc mid-grant -> IDLE next, no ack.
REQ-031 rst_n pulled low during GRANT_D with memory stalled -> all strobes/acks 0 immediately, grant_o 00, d_streak 0.
